pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_if.sv | 16 +
 rtl/pipe_skid_reg.sv | 126 ++++++++++++
 tb/tb_pipe_skid_reg.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready payload bundle for one side of a pipe_skid_reg stage.
// An entry moves at a rising edge when valid && ready; valid never waits on ready.
interface pipe_skid_reg_if #(
  parameter int DATA_W = 128,
  parameter int PC_W   = 32,
  parameter int EXC_W  = 5
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [PC_W-1:0]   pc;
  logic [EXC_W-1:0]  exc;

  modport master (output valid, output data, output pc, output exc, input ready);
  modport slave  (input valid, input data, input pc, input exc, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with optional two-entry skid buffer and bubble counter.
// Define PIPE_SKID_REG_SKID_EN for skid mode with registered in_ready.
module pipe_skid_reg #(
  parameter int               DATA_W   = 128,
  parameter int               PC_W     = 32,
  parameter int               EXC_W    = 5,
  parameter logic [EXC_W-1:0] EXC_NONE = '0,
  parameter int               CNT_W    = 16
) (
  input  logic              cpu_clk_75M,
  input  logic              cpu_rst_n,
  input  logic              flush,
  pipe_skid_reg_if.slave    up,
  pipe_skid_reg_if.master   down,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);
  localparam int ENT_W = PC_W + EXC_W + DATA_W;
  localparam logic [ENT_W-1:0] ENT_NOP = {{PC_W{1'b0}}, EXC_NONE, {DATA_W{1'b0}}};

  logic             main_v, main_v_n;
  logic [ENT_W-1:0] main_ent, main_src;
  logic             ld_main;
  logic [ENT_W-1:0] in_ent;
  logic             accept, deliver;

  assign in_ent  = {up.pc, up.exc, up.data};
  assign accept  = up.valid && up.ready;
  assign deliver = main_v && down.ready;

`ifdef PIPE_SKID_REG_SKID_EN
  logic             skid_v, skid_v_n;
  logic [ENT_W-1:0] skid_ent;
  logic             ld_main_in, ld_main_skid, ld_skid;
  logic             ready_q;

  // Next-state: flush beats everything; skid drains into main as main leaves.
  always_comb begin
    main_v_n     = main_v;
    skid_v_n     = skid_v;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      main_v_n = 1'b0;
      skid_v_n = 1'b0;
    end else if (deliver) begin
      if (skid_v) begin
        ld_main_skid = 1'b1;
        skid_v_n     = 1'b0;
      end else if (accept) begin
        ld_main_in = 1'b1;
      end else begin
        main_v_n = 1'b0;
      end
    end else if (accept) begin
      if (main_v) begin
        ld_skid  = 1'b1;
        skid_v_n = 1'b1;
      end else begin
        ld_main_in = 1'b1;
        main_v_n   = 1'b1;
      end
    end
  end

  assign ld_main  = ld_main_in || ld_main_skid;
  assign main_src = ld_main_skid ? skid_ent : in_ent;

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      skid_v   <= 1'b0;
      skid_ent <= ENT_NOP;
      ready_q  <= 1'b1;
    end else begin
      skid_v  <= skid_v_n;
      ready_q <= !skid_v_n;
      if (ld_skid) skid_ent <= in_ent;
    end
  end

  assign up.ready  = ready_q;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
`else
  always_comb begin
    main_v_n = main_v;
    ld_main  = 1'b0;
    if (flush) begin
      main_v_n = 1'b0;
    end else if (accept) begin
      ld_main  = 1'b1;
      main_v_n = 1'b1;
    end else if (deliver) begin
      main_v_n = 1'b0;
    end
  end

  assign main_src  = in_ent;
  assign up.ready  = !main_v || down.ready;
  assign occupancy = {1'b0, main_v};
`endif

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      main_v   <= 1'b0;
      main_ent <= ENT_NOP;
    end else begin
      main_v <= main_v_n;
      if (ld_main) main_ent <= main_src;
    end
  end

  // Empty slot presents a NOP bubble rather than stale payload.
  assign down.valid = main_v;
  assign down.pc    = main_v ? main_ent[ENT_W-1 -: PC_W]          : ENT_NOP[ENT_W-1 -: PC_W];
  assign down.exc   = main_v ? main_ent[DATA_W +: EXC_W]           : EXC_NONE;
  assign down.data  = main_v ? main_ent[DATA_W-1:0]                : {DATA_W{1'b0}};

  always_ff @(posedge cpu_clk_75M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      bubble_cnt <= '0;
    end else if (down.ready && !main_v && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed + random bench for pipe_skid_reg with a queue scoreboard.
module tb_pipe_skid_reg;
  localparam int DATA_W = 128;
  localparam int PC_W   = 32;
  localparam int EXC_W  = 5;
  localparam logic [EXC_W-1:0] EXC_NONE = 5'd31;
  localparam int CNT_W  = 16;
  localparam int W      = PC_W + EXC_W + DATA_W;
  localparam int N_RAND = 1500;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] bubble_cnt;

  pipe_skid_reg_if #(.DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W)) up_if ();
  pipe_skid_reg_if #(.DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W)) dn_if ();

  pipe_skid_reg #(
    .DATA_W(DATA_W), .PC_W(PC_W), .EXC_W(EXC_W), .EXC_NONE(EXC_NONE), .CNT_W(CNT_W)
  ) dut (
    .cpu_clk_75M(clk),
    .cpu_rst_n  (rst_n),
    .flush      (flush),
    .up         (up_if),
    .down       (dn_if),
    .occupancy  (occupancy),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int n_acc = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard step, sampled mid-cycle for the transfers of the coming edge.
  task automatic monitor();
    logic [W-1:0] e;
    if (!rst_n) begin
      exp_q.delete();
      return;
    end
    chk("occupancy", occupancy, exp_q.size());
    chk("out_valid", dn_if.valid, exp_q.size() != 0);
`ifdef PIPE_SKID_REG_SKID_EN
    chk("in_ready", up_if.ready, exp_q.size() < 2);
`else
    chk("in_ready", up_if.ready, (exp_q.size() == 0) || dn_if.ready);
`endif
    if (!dn_if.valid)
      chk("bubble_payload", {dn_if.pc, dn_if.exc, dn_if.data}, {{PC_W{1'b0}}, EXC_NONE, {DATA_W{1'b0}}});
    if (flush) begin
      exp_q.delete();
      return;
    end
    if (dn_if.valid && dn_if.ready) begin
      if (exp_q.size() == 0) chk("underflow", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("order", {dn_if.pc, dn_if.exc, dn_if.data}, e);
      end
    end
    if (up_if.valid && up_if.ready) begin
      exp_q.push_back({up_if.pc, up_if.exc, up_if.data});
      n_acc++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PC_W-1:0] pc, input logic [EXC_W-1:0] exc, input logic [DATA_W-1:0] d);
    up_if.valid = 1'b1;
    up_if.pc    = pc;
    up_if.exc   = exc;
    up_if.data  = d;
    tick();
    up_if.valid = 1'b0;
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; flush = 1'b0;
    up_if.valid = 1'b0; up_if.data = '0; up_if.pc = '0; up_if.exc = '0;
    dn_if.ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_out_valid", dn_if.valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_data", dn_if.data, 0);
    chk("rst_out_pc", dn_if.pc, 0);
    chk("rst_out_exc", dn_if.exc, EXC_NONE);
    chk("rst_bubble_cnt", bubble_cnt, 0);
    chk("rst_in_ready", up_if.ready, 1);

    // Bubble count increments exactly once per idle ready cycle
    dn_if.ready = 1'b1;
    repeat (3) tick();
    chk("bubble_3", bubble_cnt, 3);

    // One-cycle latency through an empty stage
    send(32'hBFC0_0000, 5'd0, 128'hA5);
    chk("lat_valid", dn_if.valid, 1);
    chk("lat_data", dn_if.data, 128'hA5);
    chk("lat_pc", dn_if.pc, 32'hBFC0_0000);
    chk("lat_exc", dn_if.exc, 0);
    chk("lat_occ", occupancy, 1);
    tick();

`ifdef PIPE_SKID_REG_SKID_EN
    // Fill main and skid, then drain in order
    dn_if.ready = 1'b0;
    send(32'h100, 5'd3, 128'h1111);
    send(32'h104, 5'd4, 128'h2222);
    chk("full_in_ready", up_if.ready, 0);
    chk("full_occ", occupancy, 2);
    chk("full_pc", dn_if.pc, 32'h100);
    dn_if.ready = 1'b1;
    tick();
    chk("drain1_pc", dn_if.pc, 32'h104);
    chk("drain1_occ", occupancy, 1);
    chk("drain1_in_ready", up_if.ready, 1);
    tick();
    chk("drain2_valid", dn_if.valid, 0);

    dn_if.ready = 1'b0;
    send(32'h300, 5'd1, 128'h3);
    send(32'h304, 5'd2, 128'h4);
    chk("preflush_occ", occupancy, 2);
`else
    // Simultaneous accept and deliver replaces the entry without a bubble
    dn_if.ready = 1'b0;
    send(32'h100, 5'd3, 128'h1111);
    chk("full_in_ready", up_if.ready, 0);
    chk("full_occ", occupancy, 1);
    dn_if.ready = 1'b1;
    up_if.valid = 1'b1; up_if.pc = 32'h104; up_if.exc = 5'd4; up_if.data = 128'h2222;
    #1;
    chk("replace_in_ready", up_if.ready, 1);
    tick();
    up_if.valid = 1'b0;
    chk("replace_pc", dn_if.pc, 32'h104);
    chk("replace_occ", occupancy, 1);
    tick();
    chk("drain_valid", dn_if.valid, 0);

    dn_if.ready = 1'b0;
    send(32'h300, 5'd1, 128'h3);
    chk("preflush_occ", occupancy, 1);
`endif

    // Flush kills held entries and the one offered alongside it
    flush = 1'b1;
    up_if.valid = 1'b1; up_if.pc = 32'h108; up_if.exc = 5'd7; up_if.data = 128'h108;
    tick();
    flush = 1'b0; up_if.valid = 1'b0;
    chk("flush_valid", dn_if.valid, 0);
    chk("flush_pc", dn_if.pc, 0);
    chk("flush_exc", dn_if.exc, EXC_NONE);
    chk("flush_occ", occupancy, 0);
    chk("flush_in_ready", up_if.ready, 1);
    dn_if.ready = 1'b1;
    repeat (3) tick();

    // Asynchronous reset between edges drops a held entry at once
    dn_if.ready = 1'b0;
    send(32'h400, 5'd5, 128'h400);
    chk("premrst_occ", occupancy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_valid", dn_if.valid, 0);
    chk("mrst_occ", occupancy, 0);
    chk("mrst_pc", dn_if.pc, 0);
    chk("mrst_in_ready", up_if.ready, 1);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    send(32'h404, 5'd6, 128'h404);
    chk("postrst_valid", dn_if.valid, 1);
    chk("postrst_pc", dn_if.pc, 32'h404);
    dn_if.ready = 1'b1;
    tick();

    // Random traffic with occasional flushes
    n_acc = 0;
    cyc = 0;
    while (n_acc < N_RAND && cyc < 20 * N_RAND) begin
      up_if.valid = 1'($urandom_range(0, 1));
      up_if.pc    = $urandom;
      up_if.exc   = 5'($urandom_range(0, 31));
      up_if.data  = {$urandom, $urandom, $urandom, $urandom};
      dn_if.ready = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 63) == 0);
      tick();
      cyc++;
    end
    chk("rand_budget", n_acc >= N_RAND, 1);
    up_if.valid = 1'b0; flush = 1'b0; dn_if.ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 10) begin
      tick();
      cyc++;
    end
    tick();
    chk("rand_drained", exp_q.size(), 0);

    // Saturation and flush immunity of the bubble counter
    repeat (70000) tick();
    chk("bubble_sat", bubble_cnt, 16'hFFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("bubble_flush", bubble_cnt, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
